uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter, successor to the fixed 8-bit even/odd-parity transmitter. It accepts words over a valid/ready handshake into an internal FIFO and serialises each word on `tx_out` as one frame: start bit, LSB-first data, optional parity, then 1 or 2 stop bits. Each bit lasts a programmable number of clocks. It sits between the GPS-receiver message formatter and the serial output pin.

## Interface
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `PARITY_MODE`, 1, parity mode:
  - 0: no parity bit.
  - 1: even; parity bit = XOR of data bits.
  - 2: odd; parity bit = inverted XOR of data bits.
- `STOP_BITS`, 1, number of stop bits; legal values 1 or 2.
- `CLKS_PER_BIT`, 16, clock cycles per bit; ≥2.
- `FIFO_DEPTH`, 4, FIFO entries; power of two, ≥2.
- `clk_tx`  in  1  block clock; all logic on its rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `data_in`  in  DATA_BITS  word to transmit.
- `data_valid`  in  1  `data_in` is valid.
- `data_ready`  out  1  FIFO can accept a word; equals !full.
- `tx_en`  in  1  frame-start permission.
- `tx_out`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is in progress (FSM not IDLE).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of words currently held in the FIFO.

## Operation
- **Reset values:** `tx_out`=1, `tx_busy`=0, `data_ready`=1, `fifo_count`=0, FSM=IDLE, FIFO emptied.
- **Write:** a word is written when `data_valid && data_ready` at a rising edge.
  - When the FIFO is full, `data_ready`=0 and `data_valid` is ignored; no word is dropped or overwritten.
- **FSM states:**
  - IDLE: `tx_out`=1.
  - START: `tx_out`=0.
  - DATA: bit index 0..DATA_BITS-1, LSB first.
  - PARITY: skipped when `PARITY_MODE`=0.
  - STOP: `tx_out`=1, STOP_BITS bit times.
- **Bit timing:** a cycle counter runs 0..CLKS_PER_BIT-1 within each bit. State and bit index advance when the counter reaches CLKS_PER_BIT-1.
- **Pop:** occurs in IDLE, or on the final cycle of STOP, when `tx_en`=1 and FIFO is non-empty.
  - The popped word goes to a shift register.
  - Parity is computed from the popped word and held for the frame.
  - FSM enters START.
- **End of frame:** on the final STOP cycle with no pop, FSM returns to IDLE.
- **`tx_en`=0:** never aborts a frame in progress; it only blocks the next pop.
- **Simultaneous write and pop:** `fifo_count` is unchanged, and both take effect.
- **Pointers:** wrap modulo FIFO_DEPTH. Full/empty are derived from `fifo_count`.
- **Input hold:** `data_in` changes after acceptance do not affect queued or active words.
- **Reset mid-frame:** `tx_out` returns to 1 immediately (asynchronously), the frame is lost, and the FIFO is cleared.

## Timing
- **Frame length:** F = (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- **Latency:** word accepted at edge k with FSM IDLE, `tx_en`=1, FIFO previously empty:
  - `fifo_count`=1 after edge k.
  - Pop at edge k+1: `tx_out`=0, `tx_busy`=1 after edge k+1, `fifo_count`=0.
- **Back-to-back:** consecutive frames have no idle cycles. The next start bit begins on the cycle immediately after the last stop-bit cycle.
- **`tx_busy`:** falls on the edge that returns FSM to IDLE, i.e. F cycles after it rose, for an isolated frame.
- **`data_ready`:** registered-equivalent; reflects `fifo_count` after the current edge, no combinational path from `data_valid`.

## Test plan
- Default params, `CLKS_PER_BIT`=4, write 0xA5 → `tx_out`, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,0(parity),1. `tx_busy` is high for exactly 44 cycles, and `tx_out` falls 1 cycle after acceptance.
- `PARITY_MODE`=2, write 0x01 → parity bit 0. `PARITY_MODE`=1, write 0x01 → parity bit 1. Write 0x00 in odd mode → parity bit 1.
- `tx_en`=0, `data_valid` held high with 5 distinct words → 4 accepted, `data_ready`=0, `fifo_count`=4. Then raise `tx_en` → 4 frames back-to-back in order, totalling 176 cycles at `CLKS_PER_BIT`=4, with no idle cycles between frames.
- Drop `tx_en` mid-frame 1 with 2 words queued → frame 1 completes intact, FSM goes to IDLE, `fifo_count`=1, `tx_out` stays high until `tx_en` rises again.
- `DATA_BITS`=7, `PARITY_MODE`=0, `STOP_BITS`=2, write 0x55 → frame of 10 bit times: 0,1,0,1,0,1,0,1,1,1.
- Assert `rst_n`=0 in the middle of the DATA state with 3 words queued → `tx_out`=1, `tx_busy`=0, `fifo_count`=0 immediately. After release, no frame starts until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable word
// size, parity, stop bits and bit period.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_tx,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic                          tx_en,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] TLAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SLAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULLC = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic                 full, empty, push, pop;
  logic                 bit_end, frame_end;
  logic [DATA_BITS-1:0] head;

  always_comb begin
    full      = (count_q == FULLC);
    empty     = (count_q == '0);
    push      = data_valid && !full;
    bit_end   = (tick_q == TLAST);
    frame_end = (state_q == S_STOP) && bit_end && (idx_q == SLAST);
    pop       = tx_en && !empty &&
                ((state_q == S_IDLE) || frame_end);
    head      = mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tick_d  = ((state_q == S_IDLE) || bit_end) ? '0 : tick_q + 1'b1;
    unique case (state_q)
      S_IDLE: ;
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == DLAST) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          idx_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == SLAST) state_d = S_IDLE;
          else idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop on the last stop cycle chains straight into the next start bit.
    if (pop) begin
      state_d = S_START;
      tick_d  = '0;
      idx_d   = '0;
      shift_d = head;
      par_d   = (PARITY_MODE == 2) ? ~^head : ^head;
    end
  end

  always_comb begin
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_tx) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk_tx or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  assign tx_out     = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign data_ready = !full;
  assign fifo_count = count_q;

endmodule
